async_oneway_transmitter: RTL and testbench



---
 rtl/async_oneway_transmitter_pkg.sv | 24 ++
 rtl/async_oneway_transmitter_if.sv | 29 ++
 rtl/async_oneway_transmitter_timer.sv | 28 ++
 rtl/async_oneway_transmitter.sv | 181 ++++++++++++++++++
 tb/tb_async_oneway_transmitter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/async_oneway_transmitter_pkg.sv
// Shared definitions for the 6-bit one-way link (transmitter and receiver side).
//   MESSAGE_SIZE : default message width carried over the link
//   LINK_CHUNK_W : data bits per link chunk (width of dout / receiver din)
//   tx_state_t   : transmitter frame FSM states
//   num_chunks() : chunks per message; always width/6 + 1 (integer division)
package async_oneway_transmitter_pkg;

   localparam int unsigned MESSAGE_SIZE = 16;
   localparam int unsigned LINK_CHUNK_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      TAIL,
      GUARD
   } tx_state_t;

   function automatic int unsigned num_chunks(input int unsigned width);
      return width / LINK_CHUNK_W + 1;
   endfunction

endpackage

// File: rtl/async_oneway_transmitter_if.sv
// Message handshake plus inter-board link wires of the one-way transmitter.
//   msg_valid/msg_data/msg_ready : upstream valid/ready message offer
//   transmit_ctrl                : frame signal to the receiver
//   packet_pulse/dout            : chunk strobe and 6-bit chunk data
//   busy                         : transmitter occupied (frame + idle guard)
// modport master : the transmitter; modport slave : upstream source / link observer
interface async_oneway_transmitter_if
   import async_oneway_transmitter_pkg::*;
#(
   parameter int unsigned MSG_W = MESSAGE_SIZE
);
   logic                    msg_valid;
   logic [MSG_W-1:0]        msg_data;
   logic                    msg_ready;
   logic                    transmit_ctrl;
   logic                    packet_pulse;
   logic [LINK_CHUNK_W-1:0] dout;
   logic                    busy;

   modport master (
      input  msg_valid, msg_data,
      output msg_ready, transmit_ctrl, packet_pulse, dout, busy
   );

   modport slave (
      output msg_valid, msg_data,
      input  msg_ready, transmit_ctrl, packet_pulse, dout, busy
   );
endinterface

// File: rtl/async_oneway_transmitter_timer.sv
// async_tx_timer: loadable down-counter shared by every timed FSM state.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : count has reached zero (counter then holds)
module async_tx_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);
endmodule

// File: rtl/async_oneway_transmitter.sv
// async_oneway_transmitter: serialises one MSG_W-bit message into 6-bit chunks
// on dout/packet_pulse, framed by transmit_ctrl, paced for the receiver's
// debouncers. Chunk 0 carries message bits [5:0]; bits above MSG_W-1 are zero.
//   clk, rst_n : single clock, asynchronous active-low reset
//   link       : async_oneway_transmitter_if.master (handshake + link wires)
// Optional macro ASYNC_TX_SKID_EN: one-entry holding register so a message can
// be accepted during a frame and sent back-to-back after the idle guard.
module async_oneway_transmitter
   import async_oneway_transmitter_pkg::*;
#(
   parameter int unsigned MSG_W       = MESSAGE_SIZE,
   parameter int unsigned LEAD_CYCLES = 8,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned TAIL_CYCLES = 8,
   parameter int unsigned IDLE_CYCLES = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   async_oneway_transmitter_if.master         link
);
   localparam int unsigned NUM_CHUNKS = num_chunks(MSG_W);
   localparam int unsigned SH_W       = NUM_CHUNKS * LINK_CHUNK_W;
   localparam int unsigned MAX_A      = (LEAD_CYCLES > HOLD_CYCLES) ? LEAD_CYCLES : HOLD_CYCLES;
   localparam int unsigned MAX_B      = (GAP_CYCLES > TAIL_CYCLES) ? GAP_CYCLES : TAIL_CYCLES;
   localparam int unsigned MAX_C      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_CYC    = (MAX_C > IDLE_CYCLES) ? MAX_C : IDLE_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);
   localparam int unsigned IDX_W      = $clog2(NUM_CHUNKS + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   // A state loaded with N lasts N+1 cycles (exit happens on the edge that sees
   // zero). LEAD keeps the full value so the accept cycle is the extra one.
   localparam logic [CNT_W-1:0] LEAD_LD  = CNT_W'(LEAD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TAIL_LD  = CNT_W'(TAIL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(IDLE_CYCLES - 1);

   tx_state_t        state;
   logic [SH_W-1:0]  shreg;
   logic [SH_W-1:0]  sh_next;
   logic [SH_W-1:0]  msg_ext;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             start_next;

   assign accept  = link.msg_valid && link.msg_ready;
   assign msg_ext = SH_W'(link.msg_data);
   assign sh_next = shreg >> LINK_CHUNK_W;

`ifdef ASYNC_TX_SKID_EN
   logic [MSG_W-1:0] hold_data;
   logic             hold_full;
   logic [SH_W-1:0]  next_msg;

   // Leaving GUARD restarts straight into LEAD if a message is waiting,
   // either already held or being offered on that very cycle.
   assign start_next = hold_full || accept;
   assign next_msg   = hold_full ? SH_W'(hold_data) : msg_ext;
`else
   assign start_next = 1'b0;
`endif

   async_tx_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE:  if (accept)   begin tmr_load = 1'b1; tmr_val = LEAD_LD;  end
         LEAD:  if (tmr_zero) begin tmr_load = 1'b1; tmr_val = HOLD_LD;  end
         HIGH:  if (tmr_zero) begin tmr_load = 1'b1; tmr_val = GAP_LD;   end
         LOW:   if (tmr_zero) begin
                   tmr_load = 1'b1;
                   tmr_val  = (idx < LAST_IDX) ? HOLD_LD : TAIL_LD;
                end
         TAIL:  if (tmr_zero) begin tmr_load = 1'b1; tmr_val = GUARD_LD; end
         GUARD: if (tmr_zero && start_next) begin tmr_load = 1'b1; tmr_val = LEAD_LD; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         shreg              <= '0;
         idx                <= '0;
         link.msg_ready     <= 1'b1;
         link.transmit_ctrl <= 1'b0;
         link.packet_pulse  <= 1'b0;
         link.dout          <= '0;
         link.busy          <= 1'b0;
`ifdef ASYNC_TX_SKID_EN
         hold_data          <= '0;
         hold_full          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               shreg              <= msg_ext;
               idx                <= '0;
               link.transmit_ctrl <= 1'b1;
               link.busy          <= 1'b1;
               state              <= LEAD;
`ifndef ASYNC_TX_SKID_EN
               link.msg_ready     <= 1'b0;
`endif
            end
            LEAD: if (tmr_zero) begin
               link.dout         <= shreg[LINK_CHUNK_W-1:0];
               link.packet_pulse <= 1'b1;
               state             <= HIGH;
            end
            HIGH: if (tmr_zero) begin
               link.dout         <= '0;
               link.packet_pulse <= 1'b0;
               state             <= LOW;
            end
            LOW: if (tmr_zero) begin
               if (idx < LAST_IDX) begin
                  idx               <= idx + IDX_W'(1);
                  shreg             <= sh_next;
                  link.dout         <= sh_next[LINK_CHUNK_W-1:0];
                  link.packet_pulse <= 1'b1;
                  state             <= HIGH;
               end else begin
                  state <= TAIL;
               end
            end
            TAIL: if (tmr_zero) begin
               link.transmit_ctrl <= 1'b0;
               state              <= GUARD;
            end
            GUARD: if (tmr_zero) begin
`ifdef ASYNC_TX_SKID_EN
               if (start_next) begin
                  shreg              <= next_msg;
                  idx                <= '0;
                  link.transmit_ctrl <= 1'b1;
                  state              <= LEAD;
               end else begin
                  link.busy <= 1'b0;
                  state     <= IDLE;
               end
`else
               link.busy      <= 1'b0;
               link.msg_ready <= 1'b1;
               state          <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
`ifdef ASYNC_TX_SKID_EN
         if (state == GUARD && tmr_zero && hold_full) begin
            hold_full      <= 1'b0;
            link.msg_ready <= 1'b1;
         end else if (accept && state != IDLE && !(state == GUARD && tmr_zero)) begin
            hold_data      <= link.msg_data;
            hold_full      <= 1'b1;
            link.msg_ready <= 1'b0;
         end
`endif
      end
   end

   param_nonzero_a: assert property (@(posedge clk)
      (LEAD_CYCLES != 0) && (HOLD_CYCLES != 0) && (GAP_CYCLES != 0) &&
      (TAIL_CYCLES != 0) && (IDLE_CYCLES != 0));

endmodule

// File: tb/tb_async_oneway_transmitter.sv
// Directed bench for async_oneway_transmitter: a 16-bit and a 12-bit instance,
// a negedge link observer acting as receiver model, hand-computed expectations.
module tb_async_oneway_transmitter;
   import async_oneway_transmitter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   async_oneway_transmitter_if #(.MSG_W(16)) if16 ();
   async_oneway_transmitter_if #(.MSG_W(12)) if12 ();

   async_oneway_transmitter #(.MSG_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .link(if16));
   async_oneway_transmitter #(.MSG_W(12)) dut12 (.clk(clk), .rst_n(rst_n), .link(if12));

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed link wires, indexed 0 = 16-bit instance, 1 = 12-bit instance.
   logic       m_ctrl[2], m_pulse[2], m_ready[2], m_busy[2];
   logic [5:0] m_dout[2];
   assign m_ctrl[0]  = if16.transmit_ctrl;  assign m_ctrl[1]  = if12.transmit_ctrl;
   assign m_pulse[0] = if16.packet_pulse;   assign m_pulse[1] = if12.packet_pulse;
   assign m_dout[0]  = if16.dout;           assign m_dout[1]  = if12.dout;
   assign m_ready[0] = if16.msg_ready;      assign m_ready[1] = if12.msg_ready;
   assign m_busy[0]  = if16.busy;           assign m_busy[1]  = if12.busy;

   // Receiver model state.
   logic        prev_ctrl[2] = '{1'b0, 1'b0};
   logic        prev_pulse[2] = '{1'b0, 1'b0};
   logic [17:0] asm_msg[2] = '{18'd0, 18'd0};
   logic [17:0] rx_hist[2][16];
   logic [5:0]  chunks[2][8];
   int unsigned hi_len[2][8], lo_len[2][8];
   int unsigned chunk_cnt[2], hi_run[2], lo_run[2], ctrl_run[2], low_run[2];
   int unsigned frames[2], last_ctrl_len[2], last_nchunks[2], gap_len[2], dout_bad[2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (m_pulse[i] && !prev_pulse[i]) begin
            if (chunk_cnt[i] < 8) begin
               chunks[i][chunk_cnt[i]] = m_dout[i];
               if (chunk_cnt[i] > 0) lo_len[i][chunk_cnt[i]-1] = lo_run[i];
            end
            asm_msg[i] = asm_msg[i] | (18'(m_dout[i]) << (6 * chunk_cnt[i]));
            hi_run[i] = 1;
         end else if (m_pulse[i]) begin
            hi_run[i]++;
            if (chunk_cnt[i] < 8 && m_dout[i] !== chunks[i][chunk_cnt[i]]) dout_bad[i]++;
         end
         if (!m_pulse[i] && prev_pulse[i]) begin
            if (chunk_cnt[i] < 8) hi_len[i][chunk_cnt[i]] = hi_run[i];
            chunk_cnt[i]++;
            lo_run[i] = 1;
         end else if (!m_pulse[i]) begin
            lo_run[i]++;
         end
         if (!m_pulse[i] && m_dout[i] != 6'd0) dout_bad[i]++;
         if (m_ctrl[i]) begin
            if (!prev_ctrl[i]) begin
               gap_len[i]  = low_run[i];
               ctrl_run[i] = 0;
            end
            ctrl_run[i]++;
         end else begin
            if (prev_ctrl[i]) begin
               if (frames[i] < 16) rx_hist[i][frames[i]] = asm_msg[i];
               last_ctrl_len[i] = ctrl_run[i];
               last_nchunks[i]  = chunk_cnt[i];
               frames[i]++;
               asm_msg[i]   = '0;
               chunk_cnt[i] = 0;
               low_run[i]   = 0;
            end
            low_run[i]++;
         end
         prev_pulse[i] = m_pulse[i];
         prev_ctrl[i]  = m_ctrl[i];
      end
   end

   task automatic drive(input int i, input logic v, input logic [15:0] d);
      if (i == 0) begin
         if16.msg_valid = v;
         if16.msg_data  = d;
      end else begin
         if12.msg_valid = v;
         if12.msg_data  = d[11:0];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_frames(input int i, input int unsigned target, input string tag);
      int unsigned n = 0;
      while (frames[i] < target && n < 2000) begin tick(); n++; end
      check(tag, 32'(frames[i] >= target), 32'd1);
   endtask

   task automatic wait_busy(input int i, input logic lvl, input string tag);
      int unsigned n = 0;
      while (m_busy[i] !== lvl && n < 2000) begin tick(); n++; end
      check(tag, 32'(m_busy[i]), 32'(lvl));
   endtask

   initial begin
      int unsigned f;
      int unsigned ready_seen;
      int unsigned busy_low;
      int unsigned n;
      logic [15:0] exp16[3];
      logic        exp_ready_busy;
`ifdef ASYNC_TX_SKID_EN
      exp_ready_busy = 1'b1;
`else
      exp_ready_busy = 1'b0;
`endif
      drive(0, 1'b0, 16'h0000);
      drive(1, 1'b0, 16'h0000);
      repeat (3) tick();
      check("rst_ctrl",  32'(if16.transmit_ctrl), 32'd0);
      check("rst_pulse", 32'(if16.packet_pulse),  32'd0);
      check("rst_dout",  32'(if16.dout),          32'd0);
      check("rst_busy",  32'(if16.busy),          32'd0);
      check("rst_ready", 32'(if16.msg_ready),     32'd1);
      check("rst_ready12", 32'(if12.msg_ready),   32'd1);
      rst_n = 1'b1;
      tick();

      // 16'hA5C3: chunks 03, 17, 0A; frame 1+8+3*32+8 = 113 cycles.
      f = frames[0];
      drive(0, 1'b1, 16'hA5C3);
      tick();
      drive(0, 1'b0, 16'hFFFF);
      check("a_busy",  32'(if16.busy),          32'd1);
      check("a_ctrl",  32'(if16.transmit_ctrl), 32'd1);
      check("a_ready", 32'(if16.msg_ready),     32'(exp_ready_busy));
      wait_frames(0, f + 1, "a_frame_timeout");
      check("a_rx",     32'(rx_hist[0][f][15:0]), 32'h0000A5C3);
      check("a_nchunk", last_nchunks[0], 32'd3);
      check("a_chunk0", 32'(chunks[0][0]), 32'h03);
      check("a_chunk1", 32'(chunks[0][1]), 32'h17);
      check("a_chunk2", 32'(chunks[0][2]), 32'h0A);
      for (int k = 0; k < 3; k++) check("a_hi_len", hi_len[0][k], 32'd16);
      check("a_lo_len0", lo_len[0][0], 32'd16);
      check("a_lo_len1", lo_len[0][1], 32'd16);
      check("a_ctrl_len", last_ctrl_len[0], 32'd113);
      wait_busy(0, 1'b0, "a_idle_timeout");
      check("a_ready_idle", 32'(if16.msg_ready), 32'd1);

      // 12'hFFF: chunks 3F, 3F, 00 -- the zero chunk still pulses.
      f = frames[1];
      drive(1, 1'b1, 16'h0FFF);
      tick();
      drive(1, 1'b0, 16'h0000);
      wait_frames(1, f + 1, "b_frame_timeout");
      check("b_rx",     32'(rx_hist[1][f][11:0]), 32'h00000FFF);
      check("b_nchunk", last_nchunks[1], 32'd3);
      check("b_chunk0", 32'(chunks[1][0]), 32'h3F);
      check("b_chunk1", 32'(chunks[1][1]), 32'h3F);
      check("b_chunk2", 32'(chunks[1][2]), 32'h00);
      check("b_hi_len2", hi_len[1][2], 32'd16);
      check("b_ctrl_len", last_ctrl_len[1], 32'd113);
      wait_busy(1, 1'b0, "b_idle_timeout");

      // Back-to-back offers: 16'h0001 then 16'h8000.
      f = frames[0];
      drive(0, 1'b1, 16'h0001);
      wait_busy(0, 1'b1, "c_accept1_timeout");
      drive(0, 1'b1, 16'h8000);
`ifdef ASYNC_TX_SKID_EN
      n = 0;
      while (m_ready[0] && n < 50) begin tick(); n++; end
      check("c_hold_accept", 32'(m_ready[0]), 32'd0);
      drive(0, 1'b0, 16'h0000);
      busy_low = 0;
      n = 0;
      while (frames[0] < f + 2 && n < 2000) begin
         tick(); n++;
         if (!m_busy[0]) busy_low++;
      end
      check("c_frames", 32'(frames[0] >= f + 2), 32'd1);
      check("c_busy_low", busy_low, 32'd0);
      check("c_gap", gap_len[0], 32'd8);
`else
      ready_seen = 0;
      n = 0;
      while (frames[0] == f && n < 2000) begin
         tick(); n++;
         if (m_ready[0]) ready_seen++;
      end
      check("c_ready_in_frame", ready_seen, 32'd0);
      wait_busy(0, 1'b0, "c_guard_timeout");
      wait_busy(0, 1'b1, "c_accept2_timeout");
      drive(0, 1'b0, 16'h0000);
      wait_frames(0, f + 2, "c_frame2_timeout");
      check("c_gap_min", 32'(gap_len[0] >= 8), 32'd1);
`endif
      check("c_rx1", 32'(rx_hist[0][f][15:0]),   32'h00000001);
      check("c_rx2", 32'(rx_hist[0][f+1][15:0]), 32'h00008000);
      wait_busy(0, 1'b0, "c_idle_timeout");

      // Reset asserted during the second HIGH phase, then a clean frame.
      f = frames[0];
      drive(0, 1'b1, 16'h0FF0);
      wait_busy(0, 1'b1, "d_accept_timeout");
      drive(0, 1'b0, 16'h0000);
      n = 0;
      while (!(m_pulse[0] && chunk_cnt[0] == 1) && n < 2000) begin tick(); n++; end
      check("d_second_high", 32'(m_pulse[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("d_rst_ctrl",  32'(if16.transmit_ctrl), 32'd0);
      check("d_rst_pulse", 32'(if16.packet_pulse),  32'd0);
      check("d_rst_dout",  32'(if16.dout),          32'd0);
      check("d_rst_busy",  32'(if16.busy),          32'd0);
      check("d_rst_ready", 32'(if16.msg_ready),     32'd1);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("d_partial_saved", frames[0], f + 1);
      f = frames[0];
      exp16[0] = 16'h1234;
      drive(0, 1'b1, exp16[0]);
      tick();
      drive(0, 1'b0, 16'h0000);
      wait_frames(0, f + 1, "d_frame_timeout");
      check("d_rx",       32'(rx_hist[0][f][15:0]), 32'h00001234);
      check("d_nchunk",   last_nchunks[0], 32'd3);
      check("d_ctrl_len", last_ctrl_len[0], 32'd113);
      wait_busy(0, 1'b0, "d_idle_timeout");

      check("dout_rule16", dout_bad[0], 32'd0);
      check("dout_rule12", dout_bad[1], 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not reach summary");
      $fatal(1);
   end

endmodule
